// File: rtl/sipo_rx8.sv
// Serial-to-parallel receiver: collects WIDTH bits over a valid/ready input
// handshake and presents the word plus its OR-reduction on a valid/ready output.
module sipo_rx8 #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       in_bit,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_any,
  output logic [$clog2(WIDTH):0]     bit_count
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] next_word;
  logic             accept;
  logic             last_bit;

  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] r, input logic b);
    if (MSB_FIRST)
      return {r[WIDTH-2:0], b};
    else
      return {b, r[WIDTH-1:1]};
  endfunction

  // HOLD only frees the input side when the consumer takes the word this cycle.
  assign in_ready  = (state == COLLECT) | out_ready;
  assign accept    = in_valid & in_ready & ~clear;
  assign last_bit  = (bit_count == CW'(WIDTH - 1));
  assign next_word = shift_in(shreg, in_bit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= COLLECT;
      shreg     <= '0;
      bit_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_any   <= 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (clear) begin
            shreg     <= '0;
            bit_count <= '0;
          end else if (accept) begin
            if (last_bit) begin
              out_data  <= next_word;
              out_any   <= |next_word;
              out_valid <= 1'b1;
              shreg     <= '0;
              bit_count <= '0;
              state     <= HOLD;
            end else begin
              shreg     <= next_word;
              bit_count <= bit_count + CW'(1);
            end
          end
        end
        HOLD: begin
          if (clear) begin
            shreg     <= '0;
            bit_count <= '0;
          end
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= COLLECT;
            // shreg is already zero here, so this starts the next word
            if (accept) begin
              shreg     <= next_word;
              bit_count <= CW'(1);
            end
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/sipo_rx8.md
Name: sipo_rx8

Overview:
- Serial-to-parallel receiver, the 1-to-8 counterpart of the 8-input OR reduction gate in the gate library.
- Accepts one bit per handshake, assembles a WIDTH-bit word and presents it with a valid/ready handshake.
- Also presents a registered OR-reduction flag of the assembled word.
- Sits between a bit-serial source (shift-out logic or testbench driver) and word-wide consumers in the tarefa gate/datapath exercises.

Parameters:
- WIDTH, 8, number of bits per assembled word (legal range 2..32).
- MSB_FIRST, 0, 0: first received bit lands in out_data[0]; 1: first received bit lands in out_data[WIDTH-1].

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clear  input  1  synchronous flush of the partial word; does not touch a held word.
- in_bit  input  1  serial data bit.
- in_valid  input  1  in_bit is valid this cycle.
- in_ready  output  1  receiver can accept in_bit this cycle.
- out_data  output  WIDTH  assembled word.
- out_valid  output  1  out_data holds a complete word.
- out_ready  input  1  consumer takes out_data this cycle.
- out_any  output  1  OR of all bits of out_data, registered with it.
- bit_count  output  clog2(WIDTH)+1  bits accepted in the current partial word.

Behaviour:
- Reset (asynchronous, on rst high), all held until rst falls:
  - out_data=0, out_valid=0, out_any=0, bit_count=0.
  - shift register=0, state=COLLECT.
  - in_ready reads 1 once rst is low.
- Accept condition: in_valid && in_ready at a rising edge. in_bit is sampled only then. in_bit is ignored when in_valid=0.
- COLLECT state: in_ready=1.
  - On accept with bit_count < WIDTH-1: shift the bit in per MSB_FIRST; bit_count += 1.
  - On accept with bit_count == WIDTH-1: the completed word (including this bit) loads out_data. out_any = |word. out_valid=1. bit_count=0. Go to HOLD.
  - Latency: out_valid rises the cycle after the WIDTH-th accept.
- HOLD state: out_valid=1; in_ready = out_ready (combinational pass-through).
  - out_ready=0: out_data, out_valid and out_any are stable. No bit is accepted.
  - out_ready=1, in_valid=0: word consumed; out_valid=0 next cycle; go to COLLECT. out_data and out_any keep their last values.
  - out_ready=1, in_valid=1: word consumed, and the bit is accepted as bit 0 of the next word in the same cycle; bit_count=1 next cycle; go to COLLECT.
  - Special case WIDTH==... not applicable, since WIDTH>=2.
- clear (synchronous, priority over an accept in the same cycle):
  - Shift register=0, bit_count=0.
  - The in_bit presented that cycle is discarded, even though in_ready reads 1.
  - In HOLD, clear does not drop the held word, and the out handshake proceeds normally in that cycle.
- Bit ordering, MSB_FIRST=0: the register shifts right, new bit enters at [WIDTH-1]; after WIDTH bits the first bit is at [0].
- Bit ordering, MSB_FIRST=1: the register shifts left, new bit enters at [0].
- rst asserted mid-word or mid-HOLD: immediate return to reset values; the partial word and any held word are lost.
- No combinational path from in_valid or in_bit to any output. The only combinational output path is out_ready -> in_ready.

Test Plan:
- Reset and idle: assert rst for 2 cycles, then drive 5 idle cycles with in_valid=0 -> out_valid=0, out_data=0, out_any=0, bit_count=0, in_ready=1.
- LSB-first word (MSB_FIRST=0): send bits 1,0,1,1,0,0,1,0 with out_ready=0 -> after the 8th accept, out_data=8'h4D, out_any=1, out_valid=1. in_ready=0 while held; the word stays stable 4 cycles.
- All-zero word, then back-pressure release: send 8 zeros -> out_data=8'h00, out_any=0. Raise out_ready for 1 cycle -> out_valid=0 next cycle, bit_count=0.
- Simultaneous consume and accept: hold 8'hFF, then drive out_ready=1 and in_valid=1 with in_bit=1 in one cycle -> word consumed, bit_count=1, state COLLECT. Then 7 more bits 0 -> out_data=8'h01.
- clear mid-word: accept 3 bits (1,1,1), then clear=1 with in_valid=1 and in_bit=1 -> bit_count=0, bit discarded. Then 8 bits 0,0,0,0,0,0,0,1 -> out_data=8'h80.
- Async reset mid-word and MSB_FIRST=1 instance:
  - Assert rst between edges after 5 accepts -> outputs 0 immediately, bit_count=0.
  - Then send 1,0,0,0,0,0,0,1 (MSB_FIRST=1) -> out_data=8'h81.
  - Then send 1,1,0,0,0,0,0,0 -> out_data=8'hC0.
